bus_turnaround_arbiter: RTL and testbench

Round-robin arbiter that generates the tristate driver enables and mux select for a shared bus built from bufif1/bufif0 drivers.
- Sits directly upstream of the tristate 2:1 mux / bus-driver stage.
- Drives each driver's enable (one-hot `grant`) and the mux select (`sel`).
- Inserts programmable dead cycles between owners, so no two drivers are ever enabled together (break-before-make against driver turn-on/turn-off delays).

---
 rtl/bus_turnaround_arbiter_pkg.sv | 27 ++
 rtl/bus_turnaround_arbiter_if.sv | 37 +++
 rtl/bus_turnaround_arbiter_rr_pick.sv | 34 +++
 rtl/bus_turnaround_arbiter.sv | 139 +++++++++++++
 tb/tb_bus_turnaround_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_turnaround_arbiter_pkg.sv
// +------------------------------------------------------------------------+
// | bus_arb_pkg                                                             |
// | Shared types, default parameters and helpers for the bus arbiter.      |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    localparam int DEF_N_SRC    = 2;
    localparam int DEF_DEAD_CYC = 1;
    localparam int DEF_HOLD_MAX = 4;

    // Bit width needed to index 'value' items, never less than one bit
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_turnaround_arbiter_if.sv
// +------------------------------------------------------------------------+
// | bus_arb_if                                                              |
// | Request/grant bundle between requesters and the turnaround arbiter.    |
// | Optional: ARB_LOCK_EN adds the 'lock' signal.                           |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

interface bus_arb_if
    import bus_arb_pkg::*;
#(
    parameter int N_SRC = DEF_N_SRC
);
    localparam int SEL_W = clog2_min1(N_SRC);

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] grant;
    logic [SEL_W-1:0] sel;
    logic             bus_busy;
    logic             turnaround;
`ifdef ARB_LOCK_EN
    logic             lock;

    modport master (input req, input lock, output grant, output sel,
                    output bus_busy, output turnaround);
    modport slave  (output req, output lock, input grant, input sel,
                    input bus_busy, input turnaround);
`else
    modport master (input req, output grant, output sel,
                    output bus_busy, output turnaround);
    modport slave  (output req, input grant, input sel,
                    input bus_busy, input turnaround);
`endif

endinterface

`default_nettype wire

// File: rtl/bus_turnaround_arbiter_rr_pick.sv
// +------------------------------------------------------------------------+
// | rr_pick                                                                 |
// | Rotating-priority encoder: first set request at or above rr_ptr.       |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
    parameter int N_SRC = 2,
    parameter int SEL_W = 1
) (
    input  wire logic [N_SRC-1:0] req,
    input  wire logic [SEL_W-1:0] rr_ptr,
    output logic                  found,
    output logic [SEL_W-1:0]      index
);

    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = 0; i < N_SRC; i++) begin
            int pos;
            pos = int'(rr_ptr) + i;
            if (pos >= N_SRC) pos = pos - N_SRC;
            if (!found && req[pos]) begin
                found = 1'b1;
                index = SEL_W'(pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_turnaround_arbiter.sv
// +------------------------------------------------------------------------+
// | bus_turnaround_arbiter                                                  |
// | Round-robin tristate-driver arbiter with dead cycles between owners.   |
// | Optional: ARB_LOCK_EN (lock input suppresses hold-time preemption).    |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module bus_turnaround_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_SRC    = DEF_N_SRC,
    parameter int DEAD_CYC = DEF_DEAD_CYC,
    parameter int HOLD_MAX = DEF_HOLD_MAX
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    bus_arb_if.master  bus
);

    localparam int SEL_W = clog2_min1(N_SRC);
    localparam int CNT_W = clog2_min1(((HOLD_MAX > DEAD_CYC) ? HOLD_MAX : DEAD_CYC) + 1);

    localparam logic [1:0]       ST_IDLE   = IDLE;
    localparam logic [1:0]       ST_GRANT  = GRANT;
    localparam logic [1:0]       ST_TURN   = TURN;
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] C_DEAD_INIT = CNT_W'(DEAD_CYC - 1);

    logic [1:0]       r_state;
    logic [N_SRC-1:0] r_grant;
    logic [SEL_W-1:0] r_sel;
    logic             r_busy;
    logic             r_turn;
    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] r_dead;

    logic             w_found;
    logic [SEL_W-1:0] w_idx;
    logic [N_SRC-1:0] w_idx_onehot;
    logic             w_owner_req;
    logic             w_others;
    logic             w_locked;
    logic             w_release;
    logic [SEL_W-1:0] w_next_ptr;

    rr_pick #(
        .N_SRC (N_SRC),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .req    (bus.req),
        .rr_ptr (r_ptr),
        .found  (w_found),
        .index  (w_idx)
    );

    // Grant is one-hot at the owner while in GRANT, so it doubles as the owner mask
    assign w_idx_onehot = {{(N_SRC-1){1'b0}}, 1'b1} << w_idx;
    assign w_owner_req  = |(bus.req & r_grant);
    assign w_others     = |(bus.req & ~r_grant);
    assign w_next_ptr   = (r_sel == SEL_W'(N_SRC - 1)) ? '0 : r_sel + 1'b1;

`ifdef ARB_LOCK_EN
    assign w_locked = bus.lock & w_owner_req;
`else
    assign w_locked = 1'b0;
`endif

    assign w_release = !w_owner_req || (!w_locked && (r_hold == C_HOLD_LAST) && w_others);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_turn  <= 1'b0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_dead  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_GRANT;
                        r_grant <= w_idx_onehot;
                        r_sel   <= w_idx;
                        r_busy  <= 1'b1;
                        r_hold  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state <= ST_TURN;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_turn  <= 1'b1;
                        r_ptr   <= w_next_ptr;
                        r_dead  <= C_DEAD_INIT;
                    end else if (!w_locked && (r_hold != C_HOLD_LAST)) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                ST_TURN: begin
                    // Requests are only looked at on the final dead cycle
                    if (r_dead == '0) begin
                        r_turn <= 1'b0;
                        if (w_found) begin
                            r_state <= ST_GRANT;
                            r_grant <= w_idx_onehot;
                            r_sel   <= w_idx;
                            r_busy  <= 1'b1;
                            r_hold  <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_dead <= r_dead - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_turn  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant      = r_grant;
    assign bus.sel        = r_sel;
    assign bus.bus_busy   = r_busy;
    assign bus.turnaround = r_turn;

endmodule

`default_nettype wire

// File: tb/tb_bus_turnaround_arbiter.sv
// +------------------------------------------------------------------------+
// | tb_bus_turnaround_arbiter                                               |
// | Self-checking bench: directed vector table, corner sequences, random.  |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_bus_turnaround_arbiter;

`ifdef ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    // Instance 0: N=2, DEAD=1, HOLD=4 ; instance 1: N=4, DEAD=3, HOLD=2
    localparam int NS [2] = '{2, 4};
    localparam int DC [2] = '{1, 3};
    localparam int HM [2] = '{4, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] reqv [2];
    logic       lockv [2];

    int checks = 0;
    int errors = 0;

    int m_owner [2];
    int m_last  [2];
    int m_dead  [2];
    int m_hold  [2];
    int m_ptr   [2];

    always #5 clk = ~clk;

    bus_arb_if #(.N_SRC(2)) ifa ();
    bus_arb_if #(.N_SRC(4)) ifb ();

    assign ifa.req = reqv[0][1:0];
    assign ifb.req = reqv[1];
`ifdef ARB_LOCK_EN
    assign ifa.lock = lockv[0];
    assign ifb.lock = lockv[1];
`endif

    bus_turnaround_arbiter #(.N_SRC(2), .DEAD_CYC(1), .HOLD_MAX(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.master)
    );

    bus_turnaround_arbiter #(.N_SRC(4), .DEAD_CYC(3), .HOLD_MAX(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.master)
    );

    typedef struct {
        logic [1:0] req;
        logic [1:0] grant;
        logic       sel;
        logic       turn;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner id (-1 = bus free), remaining dead cycles, hold age
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_last[k]  = 0;
            m_dead[k]  = 0;
            m_hold[k]  = 0;
            m_ptr[k]   = 0;
        end
    endtask

    task automatic model_pick(input int k, input logic [3:0] r);
        for (int i = 0; i < NS[k]; i++) begin
            int idx;
            idx = (m_ptr[k] + i) % NS[k];
            if (r[idx]) begin
                m_owner[k] = idx;
                m_last[k]  = idx;
                m_hold[k]  = 0;
                return;
            end
        end
    endtask

    task automatic model_step(input int k);
        logic [3:0] r;
        logic       own;
        logic       others;
        logic       locked;
        r = reqv[k] & 4'((1 << NS[k]) - 1);
        if (m_owner[k] >= 0) begin
            own    = r[m_owner[k]];
            others = (r & ~(4'd1 << m_owner[k])) != 4'd0;
            locked = LOCK_ON && own && lockv[k];
            if (!own || (!locked && m_hold[k] == HM[k] - 1 && others)) begin
                m_ptr[k]   = (m_owner[k] + 1) % NS[k];
                m_owner[k] = -1;
                m_dead[k]  = DC[k];
            end else if (!locked && m_hold[k] < HM[k] - 1) begin
                m_hold[k]++;
            end
        end else if (m_dead[k] > 0) begin
            m_dead[k]--;
            if (m_dead[k] == 0) model_pick(k, r);
        end else begin
            model_pick(k, r);
        end
    endtask

    task automatic check_dut(input int k);
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       t;
        logic [3:0] eg;
        if (k == 0) begin
            g = {2'b00, ifa.grant};
            s = {1'b0, ifa.sel};
            b = ifa.bus_busy;
            t = ifa.turnaround;
        end else begin
            g = ifb.grant;
            s = ifb.sel;
            b = ifb.bus_busy;
            t = ifb.turnaround;
        end
        eg = (m_owner[k] >= 0) ? (4'd1 << m_owner[k]) : 4'd0;
        check($sformatf("model_grant%0d", k), 32'(g), 32'(eg));
        check($sformatf("model_sel%0d", k), 32'(s), 32'(m_last[k]));
        check($sformatf("model_busy%0d", k), 32'(b), 32'(m_owner[k] >= 0));
        check($sformatf("model_turn%0d", k), 32'(t), 32'(m_dead[k] > 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        reqv[0] = '0; reqv[1] = '0;
        lockv[0] = 1'b0; lockv[1] = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        reqv[0] = '0; reqv[1] = '0;
        lockv[0] = 1'b0; lockv[1] = 1'b0;
        model_reset();

        //            req    grant  sel   turn
        tbl[0]  = '{2'b00, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{2'b01, 2'b01, 1'b0, 1'b0};
        tbl[2]  = '{2'b01, 2'b01, 1'b0, 1'b0};
        tbl[3]  = '{2'b00, 2'b00, 1'b0, 1'b1};
        tbl[4]  = '{2'b00, 2'b00, 1'b0, 1'b0};
        tbl[5]  = '{2'b10, 2'b10, 1'b1, 1'b0};
        tbl[6]  = '{2'b11, 2'b10, 1'b1, 1'b0};
        tbl[7]  = '{2'b11, 2'b10, 1'b1, 1'b0};
        tbl[8]  = '{2'b11, 2'b10, 1'b1, 1'b0};
        tbl[9]  = '{2'b11, 2'b00, 1'b1, 1'b1};
        tbl[10] = '{2'b11, 2'b01, 1'b0, 1'b0};
        tbl[11] = '{2'b10, 2'b00, 1'b0, 1'b1};
        tbl[12] = '{2'b10, 2'b10, 1'b1, 1'b0};
        tbl[13] = '{2'b01, 2'b00, 1'b1, 1'b1};
        tbl[14] = '{2'b01, 2'b01, 1'b0, 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_grant", 32'(ifa.grant), 32'd0);
        check("rst_sel", 32'(ifa.sel), 32'd0);
        check("rst_busy", 32'(ifa.bus_busy), 32'd0);
        check("rst_turn", 32'(ifa.turnaround), 32'd0);
        rst_n = 1'b1;

        // Directed vector table on instance 0
        for (int i = 0; i < 15; i++) begin
            reqv[0] = {2'b00, tbl[i].req};
            tick();
            check($sformatf("vec%0d_grant", i), 32'(ifa.grant), 32'(tbl[i].grant));
            check($sformatf("vec%0d_sel", i), 32'(ifa.sel), 32'(tbl[i].sel));
            check($sformatf("vec%0d_turn", i), 32'(ifa.turnaround), 32'(tbl[i].turn));
            check($sformatf("vec%0d_busy", i), 32'(ifa.bus_busy), 32'(tbl[i].grant != 2'b00));
        end

        // Asynchronous reset between edges while source 0 owns the bus
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", 32'(ifa.grant), 32'd0);
        check("async_rst_busy", 32'(ifa.bus_busy), 32'd0);
        check("async_rst_turn", 32'(ifa.turnaround), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        reqv[0] = 4'b0011;
        tick();
        check("post_rst_grant", 32'(ifa.grant), 32'd1);
        check("post_rst_sel", 32'(ifa.sel), 32'd0);
        check_dut(0);

        // Lone requester on source 1 keeps the bus indefinitely
        reqv[0] = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_dut(0);
        end
        check("lone_grant", 32'(ifa.grant), 32'd2);

        // Instance 1: three dead cycles with sel held on the old owner
        reqv[1] = 4'b0001;
        tick();
        check("dead3_first_grant", 32'(ifb.grant), 32'd1);
        reqv[1] = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("dead3_c%0d_grant", i), 32'(ifb.grant), 32'd0);
            check($sformatf("dead3_c%0d_sel", i), 32'(ifb.sel), 32'd0);
            check($sformatf("dead3_c%0d_turn", i), 32'(ifb.turnaround), 32'd1);
        end
        tick();
        check("dead3_next_grant", 32'(ifb.grant), 32'd2);
        check("dead3_next_sel", 32'(ifb.sel), 32'd1);
        check_dut(1);

`ifdef ARB_LOCK_EN
        do_reset();
        reqv[0] = 4'b0011;
        lockv[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("lock_c%0d_grant", i), 32'(ifa.grant), 32'd1);
        end
        lockv[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_dut(0);
        end
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) reqv[0] = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) reqv[1] = 4'($urandom_range(0, 15));
            lockv[0] = ($urandom_range(0, 7) == 0);
            lockv[1] = ($urandom_range(0, 7) == 0);
            tick();
            check_dut(0);
            check_dut(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
